fifo_rd_packer: RTL and testbench

- Read-side consumer for the dual-clock FIFO; lives entirely in the read clock domain.
- Pops FIFO words whenever data is available and packs PACK_NUM consecutive words into one wide beat.
- Presents each packed beat on a valid/ready stream to downstream logic.
- Sustains one pop per cycle when downstream is always ready; stalls pops cleanly under backpressure without losing or duplicating words.

---
 rtl/fifo_rd_packer.sv | 88 ++++++++
 tb/tb_fifo_rd_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer: pops FIFO words and packs PACK_NUM of them into one valid/ready beat.
// Define FIFO_RD_CNT_EN to add the beat_cnt_o accepted-beat counter.
module fifo_rd_packer #(
  parameter int FIFO_DAT_WD = 4,
  parameter int PACK_NUM    = 2,
  parameter int CNT_WD      = 16
) (
  input  logic                            rd_clk,
  input  logic                            rd_rstn,
  input  logic                            rd_empty_i,
  output logic                            rd_en_o,
  input  logic [FIFO_DAT_WD-1:0]          rd_dat_i,
  output logic [FIFO_DAT_WD*PACK_NUM-1:0] out_dat_o,
  output logic                            out_vld_o,
  input  logic                            out_rdy_i,
`ifdef FIFO_RD_CNT_EN
  output logic [CNT_WD-1:0]               beat_cnt_o,
`endif
  output logic                            busy_o
);

  localparam int CW = $clog2(PACK_NUM + 1);
  localparam int IW = $clog2(PACK_NUM);
  localparam logic [CW-1:0] LAST_L  = CW'(PACK_NUM - 1);
  localparam logic [CW-1:0] FULL_L  = CW'(PACK_NUM);
  localparam logic [CW:0]   LIMIT_L = (CW + 1)'(PACK_NUM);

  logic [PACK_NUM-1:0][FIFO_DAT_WD-1:0] pack_r;
  logic [CW-1:0] cnt_r;
  logic          pend_r;
  logic          out_free_s;
  logic [CW:0]   fill_s;
  logic [IW-1:0] slot_s;

  // Pop decision and status; fill_s counts held words plus the one in flight.
  always_comb begin
    out_free_s = !out_vld_o || out_rdy_i;
    fill_s     = {1'b0, cnt_r} + {{CW{1'b0}}, pend_r};
    slot_s     = cnt_r[IW-1:0];
    rd_en_o    = rd_rstn && !rd_empty_i && ((fill_s < LIMIT_L) || out_free_s);
    busy_o     = pend_r || (cnt_r != {CW{1'b0}}) || out_vld_o;
  end

  // Capture arriving words, form beats and run the output handshake.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      pack_r    <= {(PACK_NUM*FIFO_DAT_WD){1'b0}};
      cnt_r     <= {CW{1'b0}};
      pend_r    <= 1'b0;
      out_vld_o <= 1'b0;
      out_dat_o <= {(PACK_NUM*FIFO_DAT_WD){1'b0}};
    end else begin
      pend_r <= rd_en_o;
      if (out_vld_o && out_rdy_i) begin
        out_vld_o <= 1'b0;
      end
      if (pend_r) begin
        // The last word of a group bypasses the pack register when the output is free.
        if (cnt_r == LAST_L && out_free_s) begin
          out_dat_o <= {rd_dat_i, pack_r[PACK_NUM-2:0]};
          out_vld_o <= 1'b1;
          cnt_r     <= {CW{1'b0}};
        end else begin
          pack_r[slot_s] <= rd_dat_i;
          cnt_r          <= cnt_r + CW'(1);
        end
      end else if (cnt_r == FULL_L && out_free_s) begin
        out_dat_o <= pack_r;
        out_vld_o <= 1'b1;
        cnt_r     <= {CW{1'b0}};
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  // Count accepted beats, wrapping at the counter width.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      beat_cnt_o <= {CW{1'b0}} == {CW{1'b0}} ? {CNT_WD{1'b0}} : {CNT_WD{1'b0}};
    end else if (out_vld_o && out_rdy_i) begin
      beat_cnt_o <= beat_cnt_o + CNT_WD'(1);
    end else begin
      beat_cnt_o <= beat_cnt_o;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: directed PACK_NUM=2 vectors plus a randomized PACK_NUM=4 stream.
module tb_fifo_rd_packer;

  logic rd_clk = 1'b0;
  logic rd_rstn = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int failures = 0;

  // PACK_NUM=2 instance and its FIFO model / scoreboard
  logic        gap2 = 1'b1, rdy2 = 1'b0, empty2, en2, vld2, busy2;
  logic [3:0]  dat2 = 4'h0;
  logic [7:0]  odat2;
  logic [3:0]  src2 [0:63];
  logic [7:0]  exp2 [0:63];
  int          wr2 = 0, rd2 = 0, exp_wr2 = 0, exp_rd2 = 0;
`ifdef FIFO_RD_CNT_EN
  logic [3:0]  bcnt2;
  logic [15:0] bcnt4;
`endif

  // PACK_NUM=4 instance and its FIFO model / scoreboard
  logic        gap4 = 1'b1, rdy4 = 1'b0, empty4, en4, vld4, busy4;
  logic [3:0]  dat4 = 4'h0;
  logic [15:0] odat4;
  logic [3:0]  src4 [0:1023];
  logic [15:0] exp4 [0:255];
  int          wr4 = 0, rd4 = 0, exp_wr4 = 0, exp_rd4 = 0;

  assign empty2 = gap2 || (rd2 == wr2);
  assign empty4 = gap4 || (rd4 == wr4);

  fifo_rd_packer #(.FIFO_DAT_WD(4), .PACK_NUM(2), .CNT_WD(4)) dut2 (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .rd_empty_i(empty2), .rd_en_o(en2),
    .rd_dat_i(dat2), .out_dat_o(odat2), .out_vld_o(vld2), .out_rdy_i(rdy2),
`ifdef FIFO_RD_CNT_EN
    .beat_cnt_o(bcnt2),
`endif
    .busy_o(busy2));

  fifo_rd_packer #(.FIFO_DAT_WD(4), .PACK_NUM(4)) dut4 (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .rd_empty_i(empty4), .rd_en_o(en4),
    .rd_dat_i(dat4), .out_dat_o(odat4), .out_vld_o(vld4), .out_rdy_i(rdy4),
`ifdef FIFO_RD_CNT_EN
    .beat_cnt_o(bcnt4),
`endif
    .busy_o(busy4));

  // FIFO read ports: data appears the cycle after a pop; reset does not touch FIFO contents.
  always @(posedge rd_clk) begin
    if (en2) begin
      dat2 <= src2[rd2];
      rd2  <= rd2 + 1;
    end
    if (en4) begin
      dat4 <= src4[rd4];
      rd4  <= rd4 + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic push2(input logic [3:0] w);
    src2[wr2] = w;
    wr2++;
  endtask

  task automatic expect2(input logic [7:0] b);
    exp2[exp_wr2] = b;
    exp_wr2++;
  endtask

  // Monitor: scoreboard pops, hold stability, no pop on empty, fill invariant.
  logic        hold2 = 1'b0, hold4 = 1'b0;
  logic [7:0]  hdat2 = 8'h00;
  logic [15:0] hdat4 = 16'h0000;
  always @(negedge rd_clk) begin
    if (!rd_rstn) begin
      hold2 = 1'b0;
      hold4 = 1'b0;
    end else begin
      chk("no_pop_empty2", {31'd0, en2 && empty2}, 32'd0);
      chk("no_pop_empty4", {31'd0, en4 && empty4}, 32'd0);
      chk("fill_inv2", {31'd0, (int'(dut2.cnt_r) + int'(dut2.pend_r)) <= 2}, 32'd1);
      chk("fill_inv4", {31'd0, (int'(dut4.cnt_r) + int'(dut4.pend_r)) <= 4}, 32'd1);
      if (hold2) chk("hold_stable2", {23'd0, vld2, odat2}, {23'd0, 1'b1, hdat2});
      if (hold4) chk("hold_stable4", {15'd0, vld4, odat4}, {15'd0, 1'b1, hdat4});
      if (vld2 && rdy2) begin
        if (exp_rd2 < exp_wr2) chk("beat2", {24'd0, odat2}, {24'd0, exp2[exp_rd2]});
        else chk("unexpected_beat2", {24'd0, odat2}, 32'hFFFF_FFFF);
        exp_rd2++;
      end
      if (vld4 && rdy4) begin
        if (exp_rd4 < exp_wr4) chk("beat4", {16'd0, odat4}, {16'd0, exp4[exp_rd4]});
        else chk("unexpected_beat4", {16'd0, odat4}, 32'hFFFF_FFFF);
        exp_rd4++;
      end
      hold2 = vld2 && !rdy2;
      hdat2 = odat2;
      hold4 = vld4 && !rdy4;
      hdat4 = odat4;
    end
  end

  initial begin
    int ken, kv, kv2;
    // Reset state
    #12;
    chk("rst_outputs", {20'd0, en2, vld2, busy2, 1'b0, odat2}, 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rst_beat_cnt", {28'd0, bcnt2}, 32'd0);
`endif
    step(2);
    rd_rstn = 1'b1;
    gap2 = 1'b0;
    step(2);

    // Continuous stream with timing of first and second beat
    rdy2 = 1'b1;
    push2(4'h1); push2(4'h2); push2(4'h3); push2(4'h4);
    expect2(8'h21); expect2(8'h43);
    ken = -1; kv = -1; kv2 = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge rd_clk);
      if (en2 && ken < 0) ken = k;
      if (vld2) begin
        if (kv < 0) kv = k;
        else if (kv2 < 0) kv2 = k;
      end
    end
    chk("first_beat_latency", 32'(kv - ken), 32'd3);
    chk("beat_spacing", 32'(kv2 - kv), 32'd2);

    // Backpressure: first beat held, second group held in pack register, pops stalled
    step(1);
    rdy2 = 1'b0;
    push2(4'h1); push2(4'h2); push2(4'h3); push2(4'h4); push2(4'h5); push2(4'h6);
    expect2(8'h21); expect2(8'h43); expect2(8'h65);
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      if (i >= 5) chk("stall_state", {20'd0, vld2, en2, empty2, 1'b0, odat2}, {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21});
    end
    chk("stall_cnt", 32'(dut2.cnt_r), 32'd2);
    step(1);
    rdy2 = 1'b1;
    step(12);

    // Empty gap between the two words of one beat
    push2(4'hA);
    expect2(8'hBA);
    step(1);
    gap2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge rd_clk);
      chk("gap_idle_busy", {30'd0, en2, busy2}, {30'd0, 1'b0, 1'b1});
    end
    @(posedge rd_clk); #1;
    gap2 = 1'b0;
    push2(4'hB);
    step(8);

    // Async reset with a word held, one in flight and a beat presented
    rdy2 = 1'b0;
    push2(4'h9); push2(4'hA); push2(4'hB); push2(4'hC);
    push2(4'hD); push2(4'hE); push2(4'hF); push2(4'h0);
    step(4);
    chk("rst_pre_state", {29'd0, dut2.cnt_r[0], dut2.pend_r, vld2}, 32'd7);
    rd_rstn = 1'b0;
    #1;
    chk("rst_async", {20'd0, en2, vld2, busy2, 1'b0, odat2}, 32'd0);
    step(2);
    rd_rstn = 1'b1;
    rdy2 = 1'b1;
    expect2(8'hED); expect2(8'h0F);
    step(12);

    // Long stream: 15 more beats, 17 accepted since reset
    for (int i = 0; i < 30; i++) push2(4'(i));
    for (int j = 0; j < 15; j++) expect2({4'(2 * j + 1), 4'(2 * j)});
    step(80);
    chk("all_beats2", 32'(exp_rd2), 32'(exp_wr2));
`ifdef FIFO_RD_CNT_EN
    chk("beat_cnt_wrap", {28'd0, bcnt2}, 32'd1);
`endif

    // Random empty/ready over 1000 words with PACK_NUM=4
    for (int i = 0; i < 1000; i++) src4[i] = 4'($urandom);
    for (int b = 0; b < 250; b++) begin
      exp4[b] = {src4[4 * b + 3], src4[4 * b + 2], src4[4 * b + 1], src4[4 * b]};
    end
    exp_wr4 = 250;
    wr4 = 1000;
    for (int c = 0; c < 20000 && exp_rd4 < 250; c++) begin
      gap4 = ($urandom_range(0, 3) == 0);
      rdy4 = ($urandom_range(0, 3) != 0);
      step(1);
    end
    chk("all_beats4", 32'(exp_rd4), 32'd250);
    chk("all_words4", 32'(rd4), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
